// File: rtl/mdu_unit.sv
// Multi-cycle MIPS multiply/divide unit with private HI/LO registers.
// Results are computed at issue and retired after a fixed busy window.
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
    logic        wr_q, wr_d;

    logic        issue;
    logic [63:0] prod_s, prod_u;
    logic        div_s, neg_a, neg_b;
    logic [31:0] num, den, q_mag, r_mag, quo, rem;

    assign issue = start & ~req & (state_q == IDLE);

    assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign prod_u = {32'b0, src_a} * {32'b0, src_b};

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0
    assign div_s = (mdu_op == OP_DIV);
    assign neg_a = div_s & src_a[31];
    assign neg_b = div_s & src_b[31];
    assign num   = neg_a ? -src_a : src_a;
    assign den   = neg_b ? -src_b : src_b;
    assign q_mag = (den == 32'd0) ? 32'd0 : num / den;
    assign r_mag = (den == 32'd0) ? 32'd0 : num % den;
    assign quo   = (neg_a ^ neg_b) ? -q_mag : q_mag;
    assign rem   = neg_a ? -r_mag : r_mag;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        wr_d     = wr_q;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    unique case (mdu_op)
                        OP_MULT: begin
                            state_d  = MUL;
                            cnt_d    = 16'(MULT_CYCLES);
                            {hi_tmp_d, lo_tmp_d} = prod_s;
                            wr_d     = 1'b1;
                        end
                        OP_MULTU: begin
                            state_d  = MUL;
                            cnt_d    = 16'(MULT_CYCLES);
                            {hi_tmp_d, lo_tmp_d} = prod_u;
                            wr_d     = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d  = DIV;
                            cnt_d    = 16'(DIV_CYCLES);
                            hi_tmp_d = rem;
                            lo_tmp_d = quo;
                            wr_d     = (src_b != 32'd0);
                        end
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                if (cnt_q == 16'd1) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                    if (wr_q) begin
                        hi_d = hi_tmp_q;
                        lo_d = lo_tmp_q;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hi_tmp_q <= 32'd0;
            lo_tmp_q <= 32'd0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            wr_q     <= wr_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

    // The hazard unit should have stalled this; the request is dropped
    always @(posedge clk) begin
        if (reset && start && !req && busy && mdu_op != 3'd0 && mdu_op != 3'd7)
            $warning("mdu_unit: issue while busy dropped");
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus pushes expected HI/LO/latency,
// a negedge monitor pops and compares when an operation retires.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mdu_op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        req = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
        .src_a(src_a), .src_b(src_b), .req(req),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
        end
    endtask

    // Monitor: counts busy cycles, pops on retirement
    initial begin : monitor
        int run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                run = 0;
            end else if (busy === 1'b1) begin
                run++;
            end else if (run > 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(run), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_lat"}, 32'(run), 32'(e.lat));
                    check({e.name, "_hi"}, hi, e.hi);
                    check({e.name, "_lo"}, lo, e.lo);
                end
                run = 0;
            end else if (exp_q.size() > 0 && exp_q[0].lat == 0) begin
                e = exp_q.pop_front();
                check({e.name, "_busy"}, {31'd0, busy}, 32'd0);
                check({e.name, "_hi"}, hi, e.hi);
                check({e.name, "_lo"}, lo, e.lo);
            end
        end
    end

    // Reference model: architectural effect of one op
    task automatic model(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic r, output int lat);
        longint sa, sb, sq, sr;
        logic [63:0] p;
        lat = 0;
        if (r || op == 3'd0 || op == 3'd7) return;
        case (op)
            3'd1: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p = 64'(sa * sb);
                m_hi = p[63:32];
                m_lo = p[31:0];
                lat = 5;
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
                lat = 5;
            end
            3'd3: begin
                lat = 10;
                if (b != 0) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    sq = sa / sb;
                    sr = sa % sb;
                    m_lo = sq[31:0];
                    m_hi = sr[31:0];
                end
            end
            3'd4: begin
                lat = 10;
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic issue(input string nm, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic r, input bit track);
        int lat;
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        mdu_op = op;
        src_a = a;
        src_b = b;
        req = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        req = 1'b0;
        mdu_op = 3'($urandom_range(0, 7));
        src_a = $urandom;
        src_b = $urandom;
        if (track) begin
            model(op, a, b, r, lat);
            e.hi = m_hi;
            e.lo = m_lo;
            e.lat = lat;
            e.name = nm;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            check({nm, "_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        r;

        #3;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        issue("t1_mult", 3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
        wait_idle("t1");
        check("t1_hi_spec", hi, 32'hFFFFFFFF);
        check("t1_lo_spec", lo, 32'hFFFFFFFE);
        issue("t2_multu", 3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
        wait_idle("t2");
        check("t2_hi_spec", hi, 32'h00000001);
        issue("t3_div", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
        wait_idle("t3");
        check("t3_lo_spec", lo, 32'hFFFFFFFD);
        check("t3_hi_spec", hi, 32'hFFFFFFFF);
        issue("t3_divu", 3'd4, 32'd7, 32'd2, 1'b0, 1'b1);
        wait_idle("t3b");
        issue("t4_mthi", 3'd5, 32'h1234, 32'd0, 1'b0, 1'b1);
        issue("t4_mtlo", 3'd6, 32'h5678, 32'd0, 1'b0, 1'b1);
        wait_idle("t4a");
        issue("t4_div0", 3'd3, 32'd99, 32'd0, 1'b0, 1'b1);
        wait_idle("t4b");
        check("t4_hi_keep", hi, 32'h1234);
        check("t4_lo_keep", lo, 32'h5678);
        issue("t4_divovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
        wait_idle("t4c");
        check("ovf_lo_spec", lo, 32'h80000000);
        issue("t5_req", 3'd1, 32'd3, 32'd4, 1'b1, 1'b1);
        wait_idle("t5a");
        issue("t5_mult", 3'd1, 32'd1000, 32'hFFFFFFFD, 1'b0, 1'b1);
        issue("t5_drop", 3'd3, 32'd50, 32'd3, 1'b0, 1'b0);
        wait_idle("t5b");
        issue("t5_rsvd", 3'd7, 32'd77, 32'd1, 1'b0, 1'b1);
        wait_idle("t5c");

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
            r = ($urandom_range(0, 7) == 0);
            issue("rnd", op, a, b, r, 1'b1);
            wait_idle("rnd");
        end

        issue("t6_div", 3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t6_busy_async", {31'd0, busy}, 32'd0);
        check("t6_hi_async", hi, 32'd0);
        check("t6_lo_async", lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        check("t6_busy_after", {31'd0, busy}, 32'd0);
        check("t6_hi_after", hi, 32'd0);
        check("t6_lo_after", lo, 32'd0);
        check("q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
